// File: rtl/debug_leds_pkg.sv
// debug_leds_pkg: register map, PWM period and byte-select merge shared by debug_leds.
package debug_leds_pkg;
  typedef enum logic [1:0] {
    ADDR_LED_VALUE         = 2'd0,
    ADDR_BLINK_MASK        = 2'd1,
    ADDR_BLINK_HALF_PERIOD = 2'd2,
    ADDR_PWM_DUTY          = 2'd3
  } reg_addr_e;
  localparam int PWM_PERIOD = 255;
  function automatic logic [31:0] sel_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction
endpackage

// File: rtl/led_pwm.sv
// led_pwm: free-running 0..PWM_PERIOD-1 counter, on while the count is below the duty.
module led_pwm
  import debug_leds_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] i_duty,
  output logic       o_on
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cnt <= '0;
    else r_cnt <= (r_cnt == 8'(PWM_PERIOD - 1)) ? '0 : r_cnt + 8'd1;
  end
  assign o_on = r_cnt < i_duty;
endmodule

// File: rtl/debug_leds.sv
// debug_leds: Wishbone B4 pipelined target driving blinking, PWM-dimmed debug LEDs.
// Define DEBUG_LEDS_PWM_EN to build the PWM_DUTY register and led_pwm dimmer.
module debug_leds
  import debug_leds_pkg::*;
#(
  parameter int          NUM_LEDS      = 4,
  parameter logic [31:0] BLINK_DEFAULT = 32'd50_000_000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [1:0]          wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_stall_o,
  output logic [NUM_LEDS-1:0] leds_o
);
  logic                w_acc, w_wr, w_pwm_on;
  logic [31:0]         w_rd, w_duty_rd;
  logic                r_ack, r_phase;
  logic [31:0]         r_dat, r_half, r_cnt;
  logic [NUM_LEDS-1:0] r_led, r_mask, r_leds;
  assign w_acc = wb_cyc_i & wb_stb_i;
  assign w_wr  = w_acc & wb_we_i;
`ifdef DEBUG_LEDS_PWM_EN
  logic [7:0] r_duty;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_duty <= 8'hFF;
    else if (w_wr && wb_adr_i == ADDR_PWM_DUTY)
      r_duty <= 8'(sel_merge(32'(r_duty), wb_dat_i, wb_sel_i));
  end
  led_pwm u_pwm (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_duty (r_duty),
    .o_on   (w_pwm_on)
  );
  assign w_duty_rd = 32'(r_duty);
`else
  assign w_pwm_on  = 1'b1;
  assign w_duty_rd = '0;
`endif
  assign w_rd = (wb_adr_i == ADDR_LED_VALUE)         ? 32'(r_led)  :
                (wb_adr_i == ADDR_BLINK_MASK)        ? 32'(r_mask) :
                (wb_adr_i == ADDR_BLINK_HALF_PERIOD) ? r_half      : w_duty_rd;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_led  <= '0;
      r_mask <= '0;
      r_half <= BLINK_DEFAULT;
      r_leds <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !wb_we_i) ? w_rd : '0;
      if (w_wr && wb_adr_i == ADDR_LED_VALUE)
        r_led <= NUM_LEDS'(sel_merge(32'(r_led), wb_dat_i, wb_sel_i));
      if (w_wr && wb_adr_i == ADDR_BLINK_MASK)
        r_mask <= NUM_LEDS'(sel_merge(32'(r_mask), wb_dat_i, wb_sel_i));
      if (w_wr && wb_adr_i == ADDR_BLINK_HALF_PERIOD)
        r_half <= sel_merge(r_half, wb_dat_i, wb_sel_i);
      r_leds <= ((r_led & ~r_mask) | (r_mask & {NUM_LEDS{r_phase}})) & {NUM_LEDS{w_pwm_on}};
    end
  end
  // a half-period write restarts the count but leaves the phase alone
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wr && wb_adr_i == ADDR_BLINK_HALF_PERIOD) begin
      r_cnt <= '0;
    end else if (r_half == '0) begin
      r_cnt <= '0;
    end else if (r_cnt == r_half - 32'd1) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end
  assign wb_dat_o   = r_dat;
  assign wb_ack_o   = r_ack;
  assign wb_stall_o = 1'b0;
  assign leds_o     = r_leds;
endmodule
